// File: rtl/cfnp_pkg.sv
// ---------------------------------------------------------------------------
// cfnp_pkg
//   Shared constants and types for the convolution window buffer:
//   - DW_DEFAULT          default signed sample width
//   - K_MIN / K_MAX       legal kernel sizes (samples per window)
//   - STRIDE_MIN          smallest legal stride (largest is K itself)
//   - CNT_W               width of the fill / stride counters, sized so the
//                         largest kernel count K_MAX fits
//   - win_state_t         controller state encoding (FILL / STREAM)
// ---------------------------------------------------------------------------
package cfnp_pkg;

    localparam int DW_DEFAULT     = 16;
    localparam int K_DEFAULT      = 2;
    localparam int K_MIN          = 2;
    localparam int K_MAX          = 8;
    localparam int STRIDE_DEFAULT = 1;
    localparam int STRIDE_MIN     = 1;

    localparam int CNT_W = $clog2(K_MAX) + 1;

    typedef enum logic {
        ST_FILL   = 1'b0,
        ST_STREAM = 1'b1
    } win_state_t;

endpackage : cfnp_pkg

// File: rtl/conv_window_ctrl.sv
// ---------------------------------------------------------------------------
// conv_window_ctrl
//   Window-emission controller. Counts accepted samples while the window is
//   filling, then counts strides and flags the sample that completes each
//   window. Tracks frame boundaries and pulses frame_done after in_last.
//
//   Ports
//     clk         rising-edge clock
//     rst         synchronous, active-low reset
//     clr         synchronous frame clear, active-high
//     accept      a sample is shifted into the window this cycle
//     last        the accepted sample ends the frame
//     emit        combinational: the accepted sample completes a window
//     frame_done  registered one-cycle pulse after a frame ends
// ---------------------------------------------------------------------------
module conv_window_ctrl
    import cfnp_pkg::*;
#(
    parameter int K      = K_DEFAULT,
    parameter int STRIDE = STRIDE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic accept,
    input  logic last,
    output logic emit,
    output logic frame_done
);

    localparam logic [CNT_W-1:0] K_LAST = CNT_W'(K - 1);
    localparam logic [CNT_W-1:0] K_FULL = CNT_W'(K);
    localparam logic [CNT_W-1:0] S_LAST = CNT_W'(STRIDE - 1);

    win_state_t       state,      state_nxt;
    logic [CNT_W-1:0] fill_cnt,   fill_nxt;
    logic [CNT_W-1:0] stride_cnt, stride_nxt;
    logic             done_nxt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_FILL;
            fill_cnt   <= '0;
            stride_cnt <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            fill_cnt   <= fill_nxt;
            stride_cnt <= stride_nxt;
            frame_done <= done_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_nxt  = state;
        fill_nxt   = fill_cnt;
        stride_nxt = stride_cnt;
        emit       = 1'b0;
        done_nxt   = 1'b0;

        if (clr) begin
            state_nxt  = ST_FILL;
            fill_nxt   = '0;
            stride_nxt = '0;
        end else if (accept) begin
            unique case (state)
                ST_FILL: begin
                    if (fill_cnt == K_LAST) begin
                        // This sample fills the window: first emission.
                        emit       = 1'b1;
                        state_nxt  = ST_STREAM;
                        fill_nxt   = K_FULL;
                        stride_nxt = '0;
                    end else begin
                        fill_nxt = fill_cnt + 1'b1;
                    end
                end
                ST_STREAM: begin
                    // Emit when the stride counter wraps back to zero.
                    if (stride_cnt == S_LAST) begin
                        emit       = 1'b1;
                        stride_nxt = '0;
                    end else begin
                        stride_nxt = stride_cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_FILL;
                end
            endcase

            // Frame end wins over counting: restart the next frame from an
            // empty window. A window completed by this sample is still emitted.
            if (last) begin
                state_nxt  = ST_FILL;
                fill_nxt   = '0;
                stride_nxt = '0;
                done_nxt   = 1'b1;
            end
        end
    end

endmodule : conv_window_ctrl

// File: rtl/conv_window_buffer.sv
// ---------------------------------------------------------------------------
// conv_window_buffer
//   Sliding-window buffer for 1-D convolution. Accepted samples shift into a
//   K-deep register; every STRIDE samples (once K have arrived in the frame)
//   the full window is copied into an output register that is held until the
//   consumer takes it. Partial windows at the end of a frame are dropped.
//
//   Ports
//     clk         rising-edge clock
//     rst         synchronous, active-low reset
//     clr         synchronous frame clear, active-high (overrides in_valid)
//     in_valid    in_data is valid
//     in_ready    sample accepted when in_valid && in_ready
//     in_data     signed sample, DW bits
//     in_last     final sample of a frame
//     win_valid   win_data holds a window
//     win_ready   consumer takes the window this cycle
//     win_data    K*DW bits, slot 0 (oldest) in the LSBs, slot K-1 (newest)
//                 in the MSBs
//     win_last    the window was completed by the frame's in_last sample
//     frame_done  one-cycle pulse after a frame ends
// ---------------------------------------------------------------------------
module conv_window_buffer
    import cfnp_pkg::*;
#(
    parameter int DW     = DW_DEFAULT,
    parameter int K      = K_DEFAULT,
    parameter int STRIDE = STRIDE_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    input  logic            in_last,
    output logic            win_valid,
    input  logic            win_ready,
    output logic [K*DW-1:0] win_data,
    output logic            win_last,
    output logic            frame_done
);

    if ((K < K_MIN) || (K > K_MAX)) begin : g_bad_k
        $error("conv_window_buffer: K=%0d outside %0d..%0d", K, K_MIN, K_MAX);
    end
    if ((STRIDE < STRIDE_MIN) || (STRIDE > K)) begin : g_bad_stride
        $error("conv_window_buffer: STRIDE=%0d outside %0d..K", STRIDE, STRIDE_MIN);
    end

    logic [DW-1:0]   slots   [K];
    logic [DW-1:0]   shifted [K];
    logic [K*DW-1:0] win_nxt;
    logic            accept;
    logic            emit;

    // The output register can take a new window whenever it is empty or its
    // current window is being handed off this same cycle (no bubble).
    assign in_ready = !win_valid || win_ready;
    assign accept   = in_valid && in_ready && !clr;

    conv_window_ctrl #(
        .K      (K),
        .STRIDE (STRIDE)
    ) u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .accept     (accept),
        .last       (in_last),
        .emit       (emit),
        .frame_done (frame_done)
    );

    // Window contents after this cycle's shift; the emitted window is taken
    // from here so it includes the completing sample with no extra delay.
    always_comb begin
        for (int i = 0; i < K - 1; i++) begin
            shifted[i] = slots[i + 1];
        end
        shifted[K-1] = in_data;
    end

    always_comb begin
        win_nxt = '0;
        for (int i = 0; i < K; i++) begin
            win_nxt[i*DW +: DW] = shifted[i];
        end
    end

    // NOTE: the slot array is only K registers wide, so it is reset with a
    // loop like ordinary flops; a deep RAM would not be reset this way.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < K; i++) begin
                slots[i] <= '0;
            end
        end else if (accept) begin
            slots <= shifted;
        end
    end

    // Output register: a new emission replaces a window being handed off in
    // the same cycle; otherwise a handshake empties it. clr keeps win_data
    // but invalidates it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
            win_data  <= '0;
        end else if (clr) begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
        end else if (emit) begin
            win_valid <= 1'b1;
            win_data  <= win_nxt;
            win_last  <= in_last;
        end else if (win_ready) begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
        end
    end

endmodule : conv_window_buffer

// File: tb/tb_conv_window_buffer.sv
// ---------------------------------------------------------------------------
// tb_conv_window_buffer
//   Three buffer configurations (K=2/S=1, K=3/S=2, K=3/S=1) share one input
//   stream. A sliding-window model predicts each one's outputs; a negedge
//   process compares every cycle, and directed scenarios pin the model's
//   window log against hand-computed windows.
// ---------------------------------------------------------------------------
module tb_conv_window_buffer;

    localparam int DW = 16;
    localparam int ND = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, clr, in_valid, in_last, win_ready;
    logic [DW-1:0] in_data;

    logic          rdy0, rdy1, rdy2, vld0, vld1, vld2;
    logic          lst0, lst1, lst2, dn0, dn1, dn2;
    logic [2*DW-1:0] wd0;
    logic [3*DW-1:0] wd1, wd2;

    conv_window_buffer #(.DW(DW), .K(2), .STRIDE(1)) dut0 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(rdy0),
        .in_data(in_data), .in_last(in_last), .win_valid(vld0), .win_ready(win_ready),
        .win_data(wd0), .win_last(lst0), .frame_done(dn0));
    conv_window_buffer #(.DW(DW), .K(3), .STRIDE(2)) dut1 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(rdy1),
        .in_data(in_data), .in_last(in_last), .win_valid(vld1), .win_ready(win_ready),
        .win_data(wd1), .win_last(lst1), .frame_done(dn1));
    conv_window_buffer #(.DW(DW), .K(3), .STRIDE(1)) dut2 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(rdy2),
        .in_data(in_data), .in_last(in_last), .win_valid(vld2), .win_ready(win_ready),
        .win_data(wd2), .win_last(lst2), .frame_done(dn2));

    logic [127:0] act_wd [ND];
    logic         act_rdy[ND], act_vld[ND], act_lst[ND], act_dn[ND];
    assign act_wd[0] = {96'b0, wd0};
    assign act_wd[1] = {80'b0, wd1};
    assign act_wd[2] = {80'b0, wd2};
    assign act_rdy[0] = rdy0; assign act_rdy[1] = rdy1; assign act_rdy[2] = rdy2;
    assign act_vld[0] = vld0; assign act_vld[1] = vld1; assign act_vld[2] = vld2;
    assign act_lst[0] = lst0; assign act_lst[1] = lst1; assign act_lst[2] = lst2;
    assign act_dn[0]  = dn0;  assign act_dn[1]  = dn1;  assign act_dn[2]  = dn2;

    function automatic int kd(input int d);
        return (d == 0) ? 2 : 3;
    endfunction
    function automatic int sd(input int d);
        return (d == 1) ? 2 : 1;
    endfunction

    // ---------------- behavioural model ----------------
    logic [15:0]  hist   [ND][8];   // newest sample at index 7
    int           n_acc  [ND];      // samples accepted in the current frame
    logic         m_valid[ND], m_last[ND], m_done[ND];
    logic [127:0] m_data [ND];
    logic [127:0] log_win [ND][16];
    logic         log_last[ND][16];
    int           log_n  [ND];
    int           done_n [ND];

    int  n_cmp = 0;
    int  n_bad = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input int d,
                         input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[dut%0d] @%0t: got %h expected %h", name, d, $time, act, exp);
        end
    endtask

    function automatic logic [127:0] w2(input int a, input int b);
        logic [127:0] w = '0;
        w[15:0] = a[15:0]; w[31:16] = b[15:0];
        return w;
    endfunction
    function automatic logic [127:0] w3(input int a, input int b, input int c);
        logic [127:0] w = '0;
        w[15:0] = a[15:0]; w[31:16] = b[15:0]; w[47:32] = c[15:0];
        return w;
    endfunction

    task automatic model_update();
        for (int d = 0; d < ND; d++) begin
            int   k, s;
            logic acc;
            k = kd(d);
            s = sd(d);
            if (!rst) begin
                n_acc[d] = 0; m_valid[d] = 0; m_last[d] = 0; m_done[d] = 0; m_data[d] = '0;
            end else if (clr) begin
                n_acc[d] = 0; m_valid[d] = 0; m_last[d] = 0; m_done[d] = 0;
            end else begin
                acc = in_valid && (!m_valid[d] || win_ready);
                m_done[d] = 0;
                if (m_valid[d] && win_ready) begin
                    m_valid[d] = 0; m_last[d] = 0;
                end
                if (acc) begin
                    for (int j = 0; j < 7; j++) hist[d][j] = hist[d][j+1];
                    hist[d][7] = in_data;
                    n_acc[d]++;
                    if (n_acc[d] >= k && (n_acc[d] - k) % s == 0) begin
                        m_data[d] = '0;
                        for (int j = 0; j < k; j++) m_data[d][j*16 +: 16] = hist[d][8-k+j];
                        m_valid[d] = 1;
                        m_last[d]  = in_last;
                        if (log_n[d] < 16) begin
                            log_win[d][log_n[d]]  = m_data[d];
                            log_last[d][log_n[d]] = in_last;
                        end
                        log_n[d]++;
                    end
                    if (in_last) begin
                        n_acc[d] = 0;
                        m_done[d] = 1;
                        done_n[d]++;
                    end
                end
            end
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < ND; d++) begin
                check("in_ready",   d, 128'(act_rdy[d]), 128'(!m_valid[d] || win_ready));
                check("win_valid",  d, 128'(act_vld[d]), 128'(m_valid[d]));
                check("win_last",   d, 128'(act_lst[d]), 128'(m_last[d]));
                check("frame_done", d, 128'(act_dn[d]),  128'(m_done[d]));
                if (m_valid[d]) check("win_data", d, act_wd[d], m_data[d]);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input logic v, input int data, input logic last, input logic wr,
                        input logic c = 1'b0, input logic r = 1'b1);
        in_valid  = v;
        in_data   = data[15:0];
        in_last   = last;
        win_ready = wr;
        clr       = c;
        rst       = r;
        @(posedge clk);
        model_update();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        for (int d = 0; d < ND; d++) begin
            log_n[d]  = 0;
            done_n[d] = 0;
        end
    endtask

    task automatic expect_win(input int d, input int idx, input logic [127:0] w, input logic l);
        check("log_win",  d, log_win[d][idx], w);
        check("log_last", d, 128'(log_last[d][idx]), 128'(l));
    endtask

    initial begin
        for (int d = 0; d < ND; d++) begin
            n_acc[d] = 0; m_valid[d] = 0; m_last[d] = 0; m_done[d] = 0; m_data[d] = '0;
            for (int j = 0; j < 8; j++) hist[d][j] = '0;
        end
        clear_logs();
        in_valid = 0; in_data = '0; in_last = 0; win_ready = 0; clr = 0; rst = 0;

        // Reset, with win_ready low so in_ready must come from win_valid=0.
        step(0, 0, 0, 0, 0, 0);
        chk_en = 1'b1;
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("rst_win_data", 0, act_wd[0], 128'd0);
        check("rst_win_data", 2, act_wd[2], 128'd0);
        check("rst_in_ready", 1, 128'(act_rdy[1]), 128'd1);
        check("rst_win_valid", 2, 128'(act_vld[2]), 128'd0);

        // K=2,S=1: 1,2,3,4 (last on 4).
        clear_logs();
        for (int i = 1; i <= 4; i++) step(1, i, i == 4, 1);
        step(0, 0, 0, 1);
        check("t1_count", 0, 128'(log_n[0]), 128'd3);
        expect_win(0, 0, w2(1, 2), 0);
        expect_win(0, 1, w2(2, 3), 0);
        expect_win(0, 2, w2(3, 4), 1);
        check("t1_done", 0, 128'(done_n[0]), 128'd1);

        // K=3,S=2: 1..7 (last on 7), then 1..6 (last on 6).
        clear_logs();
        for (int i = 1; i <= 7; i++) step(1, i, i == 7, 1);
        for (int i = 1; i <= 6; i++) step(1, i, i == 6, 1);
        step(0, 0, 0, 1);
        check("t2_count", 1, 128'(log_n[1]), 128'd5);
        expect_win(1, 0, w3(1, 2, 3), 0);
        expect_win(1, 1, w3(3, 4, 5), 0);
        expect_win(1, 2, w3(5, 6, 7), 1);
        expect_win(1, 3, w3(1, 2, 3), 0);
        expect_win(1, 4, w3(3, 4, 5), 0);
        check("t2_done", 1, 128'(done_n[1]), 128'd2);

        // Backpressure on K=2,S=1: window {1,2} held for 3 cycles.
        clear_logs();
        step(1, 1, 0, 0);
        step(1, 2, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 3, 0, 0);
            check("bp_in_ready", 0, 128'(act_rdy[0]), 128'd0);
            check("bp_hold",     0, act_wd[0], w2(1, 2));
        end
        step(1, 3, 0, 1);
        check("bp_release", 0, act_wd[0], w2(2, 3));
        step(1, 4, 1, 1);
        step(0, 0, 0, 1);
        check("t3_count", 0, 128'(log_n[0]), 128'd3);
        expect_win(0, 2, w2(3, 4), 1);

        // K=3: lone sample with in_last, then a clean frame 1,2,3.
        clear_logs();
        step(1, 5, 1, 1);
        step(0, 0, 0, 1);
        check("t4_nowin",  2, 128'(log_n[2]), 128'd0);
        check("t4_done",   2, 128'(done_n[2]), 128'd1);
        for (int i = 1; i <= 3; i++) step(1, i, i == 3, 1);
        step(0, 0, 0, 1);
        check("t4_count", 2, 128'(log_n[2]), 128'd1);
        expect_win(2, 0, w3(1, 2, 3), 1);

        // Reset mid-frame on K=3, then 7,8,9.
        clear_logs();
        step(1, 1, 0, 1);
        step(1, 2, 0, 1);
        step(1, 6, 0, 1, 0, 0);
        for (int i = 7; i <= 9; i++) step(1, i, i == 9, 1);
        step(0, 0, 0, 1);
        check("t5_count", 2, 128'(log_n[2]), 128'd1);
        expect_win(2, 0, w3(7, 8, 9), 1);

        // clr together with a valid sample.
        clear_logs();
        step(1, 1, 0, 1);
        step(1, 2, 0, 0);
        step(1, 9, 0, 0, 1);
        check("clr_valid", 0, 128'(act_vld[0]), 128'd0);
        check("clr_done",  0, 128'(act_dn[0]),  128'd0);
        for (int i = 3; i <= 5; i++) step(1, i, i == 5, 1);
        step(0, 0, 0, 1);
        check("t6_count", 2, 128'(log_n[2]), 128'd1);
        expect_win(2, 0, w3(3, 4, 5), 1);
        check("t6_count", 0, 128'(log_n[0]), 128'd3);
        expect_win(0, 1, w2(3, 4), 0);

        step(0, 0, 0, 1);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_conv_window_buffer
